// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the fetch/data RAM port arbiter.
// Size codes, FSM states, owner encoding and beat-count helper.
package mem_port_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    typedef struct packed {
        logic        owner;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    // Index of the final beat; size 2'b11 falls through to word.
    function automatic logic [1:0] last_beat(input logic [1:0] size);
        logic [1:0] r;
        unique case (1'b1)
            (size == SZ_BYTE): r = 2'd0;
            (size == SZ_HALF): r = 2'd1;
            default:           r = 2'd3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_beat_seq.sv
// Beat counter and big-endian byte-lane steering for one transfer.
// Holds the read assembly register, cleared at every grant.
module mem_beat_seq
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        step,
    input  logic        rd,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [7:0]  ram_rdata,
    output logic [1:0]  beat,
    output logic        last,
    output logic [7:0]  wbyte,
    output logic [31:0] asm_data
);

    logic [1:0]  beat_q, beat_d;
    logic [31:0] asm_q, asm_d;
    logic [1:0]  lane;
    logic [4:0]  lsb;

    // Beat 0 maps to the most significant lane of the access.
    assign lane = last_beat(size) - beat_q;
    assign lsb  = {lane, 3'b000};

    assign beat     = beat_q;
    assign last     = (beat_q == last_beat(size));
    assign wbyte    = wdata[lsb +: 8];
    assign asm_data = asm_q;

    always_comb begin
        beat_d = beat_q;
        asm_d  = asm_q;
        if (start) begin
            beat_d = 2'd0;
            asm_d  = '0;
        end else if (step) begin
            beat_d = beat_q + 2'd1;
            if (rd) begin
                asm_d[lsb +: 8] = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            asm_q  <= '0;
        end else begin
            beat_q <= beat_d;
            asm_q  <= asm_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide RAM between fetch and data ports, one beat per byte.
// Data side wins unless fetch has waited STARVE_LIMIT data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_rw,
    input  logic [1:0]        dm_size,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [1:0]        state_q, state_d;
    xfer_t             req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     starve_q, starve_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       dm_rdata_q, dm_rdata_d;

    logic        seq_start;
    logic        gnt_dm;
    logic        in_xfer;
    logic        in_done;
    logic [1:0]  beat;
    logic        last;
    logic [7:0]  wbyte;
    logic [31:0] asm_data;

    logic unused_addr_hi;
    assign unused_addr_hi = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

    assign in_xfer = (state_q == ST_XFER);
    assign in_done = (state_q == ST_DONE);
    assign gnt_dm  = dm_req && !(if_req && starve_q == LIMIT);

    mem_beat_seq u_seq (
        .clk       (CLK),
        .rst_n     (CLR),
        .start     (seq_start),
        .step      (in_xfer),
        .rd        (in_xfer && !req_q.rw),
        .size      (req_q.size),
        .wdata     (req_q.wdata),
        .ram_rdata (ram_rdata),
        .beat      (beat),
        .last      (last),
        .wbyte     (wbyte),
        .asm_data  (asm_data)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        seq_start  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (if_req || dm_req) begin
                    seq_start = 1'b1;
                    state_d   = ST_XFER;
                    if (gnt_dm) begin
                        req_d.owner = OWN_DM;
                        req_d.rw    = dm_rw;
                        req_d.size  = dm_size;
                        req_d.wdata = dm_wdata;
                        addr_d      = dm_addr[ADDR_W-1:0];
                        if (if_req && starve_q != LIMIT) begin
                            starve_d = starve_q + CW'(1);
                        end
                    end else begin
                        req_d.owner = OWN_IF;
                        req_d.rw    = 1'b0;
                        req_d.size  = SZ_WORD;
                        req_d.wdata = '0;
                        addr_d      = if_addr[ADDR_W-1:0];
                        starve_d    = '0;
                    end
                end
            end
            ST_XFER: begin
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!req_q.rw) begin
                    if (req_q.owner == OWN_IF) begin
                        if_rdata_d = asm_data;
                    end else begin
                        dm_rdata_d = asm_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            addr_q     <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Read data is forwarded during DONE so it is valid with the ready pulse.
    assign if_ready = in_done && (req_q.owner == OWN_IF);
    assign dm_ready = in_done && (req_q.owner == OWN_DM);
    assign if_rdata = (if_ready && !req_q.rw) ? asm_data : if_rdata_q;
    assign dm_rdata = (dm_ready && !req_q.rw) ? asm_data : dm_rdata_q;

    assign ram_en    = in_xfer;
    assign ram_we    = in_xfer && req_q.rw;
    assign ram_addr  = in_xfer ? addr_q + ADDR_W'(beat) : '0;
    assign ram_wdata = ram_we ? wbyte : 8'h00;
    assign busy      = in_xfer || in_done;

endmodule
